// File: rtl/multicycle_mainfsm.sv
// Main control FSM for the multicycle ARM datapath: sequences fetch/decode/execute/memory/writeback
// and issues unconditioned write strobes. It also keeps a retired-instruction counter.
module multicycle_mainfsm #(
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      Op,
  input  logic [5:0]      Funct,
  input  logic            mem_ready,
  output logic            IRWrite,
  output logic            AdrSrc,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic            ALUOp,
  output logic [1:0]      ResultSrc,
  output logic            NextPC,
  output logic            RegW,
  output logic            MemW,
  output logic            Branch,
  output logic            instr_done,
  output logic [CNTW-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  typedef struct packed {
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       aluop;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       done;
    logic       fetch;
    logic       decode;
    logic       memwr;
  } ctrl_t;

  state_t          r_state;
  state_t          w_next;
  ctrl_t           r_ctrl;
  logic [CNTW-1:0] r_instret;
  logic            w_done;
  logic            w_unused_funct;

  // Moore field decode for a state; registered against the next state so outputs
  // come straight from flops while remaining aligned with r_state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.fetch     = 1'b1;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.decode    = 1'b1;
      end
      S_MEMADR: begin
        c.alusrcb = 2'b01;
      end
      S_MEMRD: begin
        c.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regw      = 1'b1;
        c.done      = 1'b1;
      end
      S_MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
        c.memwr  = 1'b1;
      end
      S_EXECR: begin
        c.aluop = 1'b1;
      end
      S_EXECI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 1'b1;
      end
      S_ALUWB: begin
        c.regw = 1'b1;
        c.done = 1'b1;
      end
      S_BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Handshake-dependent terms stay combinational; reset masks every strobe.
  assign w_done = reset & (r_ctrl.done
                         | (r_ctrl.memwr & mem_ready)
                         | (r_ctrl.decode & (Op == 2'b11)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode_ctrl(S_FETCH);
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next);
      if (w_done) begin
        r_instret <= r_instret + CNTW'(1);
      end
    end
  end

  assign IRWrite    = reset & r_ctrl.fetch & mem_ready;
  assign NextPC     = reset & r_ctrl.fetch & mem_ready;
  assign AdrSrc     = r_ctrl.adrsrc;
  assign ALUSrcA    = r_ctrl.alusrca;
  assign ALUSrcB    = r_ctrl.alusrcb;
  assign ALUOp      = r_ctrl.aluop;
  assign ResultSrc  = r_ctrl.resultsrc;
  assign RegW       = reset & r_ctrl.regw;
  assign MemW       = reset & r_ctrl.memw;
  assign Branch     = reset & r_ctrl.branch;
  assign instr_done = w_done;
  assign instret    = r_instret;

  assign w_unused_funct = ^Funct[4:1];

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Self-checking bench for multicycle_mainfsm: per-instruction cycle schedules built from
// the instruction class, with random memory stalls, compared cycle by cycle.
module tb_multicycle_mainfsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [5:0]  Funct = '0;
  logic        mem_ready = 1'b0;

  logic        IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, instr_done;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [31:0] instret;
  logic        IRWrite4, AdrSrc4, ALUSrcA4, ALUOp4, NextPC4, RegW4, MemW4, Branch4, instr_done4;
  logic [1:0]  ALUSrcB4, ResultSrc4;
  logic [3:0]  instret4;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cnt   = 0;

  localparam int K_FETCH = 0, K_DEC = 1, K_MADR = 2, K_MRD = 3, K_MWB = 4,
                 K_MWR = 5, K_EXR = 6, K_EXI = 7, K_AWB = 8, K_BR = 9;

  always #5 clk = ~clk;

  multicycle_mainfsm #(.CNTW(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .instr_done(instr_done), .instret(instret)
  );

  multicycle_mainfsm #(.CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite4), .AdrSrc(AdrSrc4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
    .ALUOp(ALUOp4), .ResultSrc(ResultSrc4), .NextPC(NextPC4), .RegW(RegW4),
    .MemW(MemW4), .Branch(Branch4), .instr_done(instr_done4), .instret(instret4)
  );

  wire logic [12:0] w_obs  = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                              NextPC, RegW, MemW, Branch, instr_done};
  wire logic [12:0] w_obs4 = {IRWrite4, AdrSrc4, ALUSrcA4, ALUSrcB4, ALUOp4, ResultSrc4,
                              NextPC4, RegW4, MemW4, Branch4, instr_done4};
  wire logic [5:0]  w_strb = {IRWrite, NextPC, RegW, MemW, Branch, instr_done};

  // Output table per instruction phase, straight from the behavioural description.
  function automatic logic [12:0] expect_out(input int k, input logic m, input logic [1:0] op);
    logic irw, adr, a, aop, npc, rw, mw, br, dn;
    logic [1:0] b, rs;
    {irw, adr, a, aop, npc, rw, mw, br, dn} = '0;
    b = 2'b00;
    rs = 2'b00;
    case (k)
      K_FETCH: begin a = 1; b = 2'b10; rs = 2'b10; irw = m; npc = m; end
      K_DEC:   begin a = 1; b = 2'b10; rs = 2'b10; dn = (op == 2'b11); end
      K_MADR:  begin b = 2'b01; end
      K_MRD:   begin adr = 1; end
      K_MWB:   begin rs = 2'b01; rw = 1; dn = 1; end
      K_MWR:   begin adr = 1; mw = 1; dn = m; end
      K_EXR:   begin aop = 1; end
      K_EXI:   begin b = 2'b01; aop = 1; end
      K_AWB:   begin rw = 1; dn = 1; end
      K_BR:    begin b = 2'b01; rs = 2'b10; br = 1; dn = 1; end
      default: ;
    endcase
    return {irw, adr, a, b, aop, rs, npc, rw, mw, br, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k, input logic m);
    logic [12:0] e;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = m;
    #1;
    e = expect_out(k, m, Op);
    check($sformatf("outs k=%0d op=%0d m=%0b", k, Op, m), 32'(w_obs), 32'(e));
    check($sformatf("outs4 k=%0d", k), 32'(w_obs4), 32'(e));
    @(posedge clk);
    #1;
    if (e[0]) cnt++;
    check("instret", instret, cnt);
    check("instret4", 32'(instret4), 32'(cnt % 16));
  endtask

  task automatic reset_cycle(input logic m);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = m;
    #1;
    check($sformatf("rst_strobes m=%0b", m), 32'(w_strb), 32'd0);
    @(posedge clk);
    #1;
    cnt = 0;
    check("rst_instret", instret, 32'd0);
    check("rst_instret4", 32'(instret4), 32'd0);
  endtask

  // abort_after = 0 runs the whole instruction; otherwise only that many cycles run.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input int fst, input int mst, input int abort_after);
    int   kq[$];
    logic mq[$];
    Op = op;
    Funct = fn;
    for (int i = 0; i < fst; i++) begin kq.push_back(K_FETCH); mq.push_back(1'b0); end
    kq.push_back(K_FETCH); mq.push_back(1'b1);
    kq.push_back(K_DEC);   mq.push_back(1'($urandom_range(0, 1)));
    case (op)
      2'b00: begin
        kq.push_back(fn[5] ? K_EXI : K_EXR); mq.push_back(1'($urandom_range(0, 1)));
        kq.push_back(K_AWB);                 mq.push_back(1'($urandom_range(0, 1)));
      end
      2'b01: begin
        kq.push_back(K_MADR); mq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mst; i++) begin
          kq.push_back(fn[0] ? K_MRD : K_MWR); mq.push_back(1'b0);
        end
        kq.push_back(fn[0] ? K_MRD : K_MWR); mq.push_back(1'b1);
        if (fn[0]) begin kq.push_back(K_MWB); mq.push_back(1'($urandom_range(0, 1))); end
      end
      2'b10: begin
        kq.push_back(K_BR); mq.push_back(1'($urandom_range(0, 1)));
      end
      default: ;
    endcase
    for (int i = 0; i < kq.size(); i++) begin
      if (abort_after != 0 && i >= abort_after) break;
      step(kq[i], mq[i]);
    end
  endtask

  initial begin
    reset_cycle(1'b0);
    reset_cycle(1'b1);

    run_instr(2'b00, 6'b001000, 0, 0, 0);   // ADD reg
    check("add_count", instret, 32'd1);
    run_instr(2'b00, 6'b101001, 1, 0, 0);   // ADD imm
    run_instr(2'b01, 6'b011001, 0, 2, 0);   // LDR, MEMRD held 3 cycles
    run_instr(2'b01, 6'b011000, 0, 1, 0);   // STR
    run_instr(2'b01, 6'b011000, 0, 0, 0);   // STR no stall
    run_instr(2'b10, 6'b000000, 0, 0, 0);   // B
    run_instr(2'b11, 6'b111111, 0, 0, 0);   // undefined -> NOP

    // STR aborted by reset while stalled in the write phase
    run_instr(2'b01, 6'b000000, 0, 5, 4);
    reset_cycle(1'b0);
    reset_cycle(1'b1);
    reset_cycle(1'b1);
    run_instr(2'b00, 6'b000000, 0, 0, 0);
    check("post_abort_count", instret, 32'd1);

    // FETCH stall then many random instructions, crossing the 4-bit wrap
    run_instr(2'b10, 6'b000000, 3, 0, 0);
    for (int n = 0; n < 60; n++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 0);
    end
    check("final_count_ge17", 32'(cnt >= 17), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
